// File: rtl/ifu_rd_responder_if.sv
// Instruction-fetch read channel (AR/R) plus the SRAM read port of the responder.
// The slave modport is the responder's view; master is the fetch controller / SRAM side.
interface ifu_rd_responder_if #(
  parameter int unsigned DEPTH_LOG2 = 16
);
  logic                  ifu_ARVALID;
  logic                  ifu_ARREADY;
  logic [63:0]           ifu_ARADDR;
  logic [2:0]            ifu_ARPORT;
  logic                  ifu_RVALID;
  logic                  ifu_RREADY;
  logic [63:0]           ifu_RDATA;
  logic [1:0]            ifu_RRESP;
  logic                  mem_en;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [63:0]           mem_rdata;

  modport slave (
    input  ifu_ARVALID, ifu_ARADDR, ifu_ARPORT, ifu_RREADY, mem_rdata,
    output ifu_ARREADY, ifu_RVALID, ifu_RDATA, ifu_RRESP, mem_en, mem_addr
  );

  modport master (
    output ifu_ARVALID, ifu_ARADDR, ifu_ARPORT, ifu_RREADY, mem_rdata,
    input  ifu_ARREADY, ifu_RVALID, ifu_RDATA, ifu_RRESP, mem_en, mem_addr
  );
endinterface

// File: rtl/ifu_rd_responder.sv
// Single-outstanding instruction-fetch read responder in front of a 64-bit synchronous SRAM.
// Fixed AR-to-RVALID latency, RREADY backpressure, alignment/range error responses.
module ifu_rd_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH_LOG2 = 16,
  parameter int unsigned LAT        = 1
) (
  input  logic                clk,
  input  logic                rst,
  ifu_rd_responder_if.slave   bus
);

  localparam int unsigned      CNT_W       = 4;
  localparam logic [63:0]      END_ADDR    = BASE_ADDR + (64'd8 << DEPTH_LOG2);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [1:0]       RESP_DECERR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [63:0]        addr_q;
  logic [2:0]         port_q;
  logic [1:0]         cls_q;
  logic               rvalid_q;
  logic [1:0]         rresp_q;
  logic [63:0]        rdata_q;
  logic               first_q;

  logic               arready_c;
  logic               ar_hs_c;
  logic [1:0]         cls_in_c;
  logic [63:0]        rdata_live_c;
  logic               unused_port_c;

  // Misalignment wins over out-of-range.
  function automatic logic [1:0] classify(input logic [63:0] a);
    if (a[1:0] != 2'b00) begin
      return RESP_SLVERR;
    end else if ((a < BASE_ADDR) || (a >= END_ADDR)) begin
      return RESP_DECERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE_ADDR;
    return DEPTH_LOG2'(off >> 3);
  endfunction

  assign arready_c = !rst && ((state_q == ST_IDLE) ||
                              ((state_q == ST_RESP) && bus.ifu_RREADY));
  assign ar_hs_c   = bus.ifu_ARVALID && arready_c;
  assign cls_in_c  = classify(bus.ifu_ARADDR);

  // SRAM output is only valid in the first response cycle; the instruction always lands in [31:0].
  assign rdata_live_c = (rresp_q == RESP_OKAY)
                      ? {bus.mem_rdata[63:32],
                         addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0]}
                      : 64'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      port_q   <= '0;
      cls_q    <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      first_q  <= 1'b0;
    end else begin
      first_q <= 1'b0;
      if (first_q) begin
        rdata_q <= rdata_live_c;
      end
      if (ar_hs_c) begin
        addr_q <= bus.ifu_ARADDR;
        port_q <= bus.ifu_ARPORT;
        cls_q  <= cls_in_c;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (ar_hs_c) begin
            if (LAT == 1) begin
              state_q  <= ST_RESP;
              rvalid_q <= 1'b1;
              rresp_q  <= cls_in_c;
              first_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_ONE) begin
            state_q  <= ST_RESP;
            cnt_q    <= '0;
            rvalid_q <= 1'b1;
            rresp_q  <= cls_q;
            first_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (bus.ifu_RREADY) begin
            if (ar_hs_c) begin
              // Overlapped accept: LAT=1 stays in RESP for back-to-back beats.
              if (LAT == 1) begin
                rvalid_q <= 1'b1;
                rresp_q  <= cls_in_c;
                first_q  <= 1'b1;
              end else begin
                state_q  <= ST_WAIT;
                cnt_q    <= CNT_LOAD;
                rvalid_q <= 1'b0;
              end
            end else begin
              state_q  <= ST_IDLE;
              rvalid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Read is issued in the cycle before RVALID rises; LAT=1 issues straight from the handshake.
  assign bus.mem_en   = (LAT == 1)
                      ? (ar_hs_c && (cls_in_c == RESP_OKAY))
                      : (!rst && (state_q == ST_WAIT) && (cnt_q == CNT_ONE) &&
                         (cls_q == RESP_OKAY));
  assign bus.mem_addr = (LAT == 1) ? word_idx(bus.ifu_ARADDR) : word_idx(addr_q);

  assign bus.ifu_ARREADY = arready_c;
  assign bus.ifu_RVALID  = rvalid_q;
  assign bus.ifu_RRESP   = rresp_q;
  assign bus.ifu_RDATA   = first_q ? rdata_live_c : rdata_q;

  // Protection bits are captured but have no effect on the response.
  assign unused_port_c = ^port_q;

endmodule

// File: tb/tb_ifu_rd_responder.sv
// Directed bench for ifu_rd_responder: LAT=1 vector table, LAT=3 streaming/backpressure/errors,
// and asynchronous reset abort at LAT=4.
module tb_ifu_rd_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ifu_rd_responder_if #(.DEPTH_LOG2(16)) b1 ();
  ifu_rd_responder_if #(.DEPTH_LOG2(16)) b3 ();
  ifu_rd_responder_if #(.DEPTH_LOG2(16)) b4 ();

  ifu_rd_responder #(.BASE_ADDR(64'h0000_0000_8000_0000), .DEPTH_LOG2(16), .LAT(1))
    u_lat1 (.clk(clk), .rst(rst), .bus(b1));
  ifu_rd_responder #(.BASE_ADDR(64'h0000_0000_8000_0000), .DEPTH_LOG2(16), .LAT(3))
    u_lat3 (.clk(clk), .rst(rst), .bus(b3));
  ifu_rd_responder #(.BASE_ADDR(64'h0000_0000_8000_0000), .DEPTH_LOG2(16), .LAT(4))
    u_lat4 (.clk(clk), .rst(rst), .bus(b4));

  // SRAM contents: word 0 is fixed, others encode their index in both halves.
  function automatic logic [63:0] word_of(input logic [15:0] idx);
    if (idx == 16'd0) return 64'h0000_0013_0010_0093;
    return {32'hA000_0000 | 32'(idx), 32'hB000_0000 | 32'(idx)};
  endfunction

  // Data is only meaningful the cycle after mem_en; otherwise present garbage.
  always @(posedge clk) begin
    b1.mem_rdata <= b1.mem_en ? word_of(b1.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    b3.mem_rdata <= b3.mem_en ? word_of(b3.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    b4.mem_rdata <= b4.mem_en ? word_of(b4.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  port;
    logic [1:0]  resp;
    logic [63:0] data;
    logic        en;
    logic [15:0] idx;
  } vec_t;

  vec_t        vt [14];
  logic [63:0] a3 [3]   = '{64'h8000_0000, 64'h8000_0008, 64'h8000_0010};
  logic [63:0] d3 [3]   = '{64'h0000_0013_0010_0093, 64'hA000_0001_B000_0001,
                            64'hA000_0002_B000_0002};
  logic [63:0] ea [2]   = '{64'h8000_0002, 64'h8008_0000};
  logic [1:0]  er [2]   = '{2'b10, 2'b11};

  initial begin
    vt[0]  = '{64'h0000_0000_8000_0000, 3'd0, 2'b00, 64'h0000_0013_0010_0093, 1'b1, 16'h0000};
    vt[1]  = '{64'h0000_0000_8000_0004, 3'd5, 2'b00, 64'h0000_0013_0000_0013, 1'b1, 16'h0000};
    vt[2]  = '{64'h0000_0000_8000_0008, 3'd1, 2'b00, 64'hA000_0001_B000_0001, 1'b1, 16'h0001};
    vt[3]  = '{64'h0000_0000_8000_000C, 3'd7, 2'b00, 64'hA000_0001_A000_0001, 1'b1, 16'h0001};
    vt[4]  = '{64'h0000_0000_8007_FFF8, 3'd2, 2'b00, 64'hA000_FFFF_B000_FFFF, 1'b1, 16'hFFFF};
    vt[5]  = '{64'h0000_0000_8007_FFFC, 3'd3, 2'b00, 64'hA000_FFFF_A000_FFFF, 1'b1, 16'hFFFF};
    vt[6]  = '{64'h0000_0000_8000_0002, 3'd0, 2'b10, 64'h0,                   1'b0, 16'h0000};
    vt[7]  = '{64'h0000_0000_8000_0001, 3'd4, 2'b10, 64'h0,                   1'b0, 16'h0000};
    vt[8]  = '{64'h0000_0000_7FFF_FFFC, 3'd0, 2'b11, 64'h0,                   1'b0, 16'h0000};
    vt[9]  = '{64'h0000_0000_8008_0000, 3'd6, 2'b11, 64'h0,                   1'b0, 16'h0000};
    vt[10] = '{64'h0000_0000_8008_0002, 3'd0, 2'b10, 64'h0,                   1'b0, 16'h0000};
    vt[11] = '{64'h0000_0000_0000_0000, 3'd1, 2'b11, 64'h0,                   1'b0, 16'h0000};
    vt[12] = '{64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 2'b11, 64'h0,                   1'b0, 16'h0000};
    vt[13] = '{64'h0000_0000_8004_0010, 3'd3, 2'b00, 64'hA000_8002_B000_8002, 1'b1, 16'h8002};

    b1.ifu_ARVALID = 1'b0; b1.ifu_ARADDR = '0; b1.ifu_ARPORT = '0; b1.ifu_RREADY = 1'b1;
    b3.ifu_ARVALID = 1'b0; b3.ifu_ARADDR = '0; b3.ifu_ARPORT = '0; b3.ifu_RREADY = 1'b1;
    b4.ifu_ARVALID = 1'b0; b4.ifu_ARADDR = '0; b4.ifu_ARPORT = '0; b4.ifu_RREADY = 1'b1;

    // Reset values, with a valid request pending on the LAT=1 port.
    b1.ifu_ARVALID = 1'b1;
    b1.ifu_ARADDR  = 64'h8000_0000;
    #2;
    chk("rst_arready", b1.ifu_ARREADY, 1'b0);
    chk("rst_mem_en",  b1.mem_en,      1'b0);
    chk("rst_rvalid",  b1.ifu_RVALID,  1'b0);
    chk("rst_rdata",   b1.ifu_RDATA,   64'h0);
    chk("rst_rresp",   b1.ifu_RRESP,   2'b00);
    chk("rst_arready3", b3.ifu_ARREADY, 1'b0);
    chk("rst_rvalid4", b4.ifu_RVALID,  1'b0);
    b1.ifu_ARVALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // LAT=1 single transactions from the table.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_arready_idle", i), b1.ifu_ARREADY, 1'b1);
      b1.ifu_ARVALID = 1'b1;
      b1.ifu_ARADDR  = vt[i].addr;
      b1.ifu_ARPORT  = vt[i].port;
      #1;
      chk($sformatf("v%0d_mem_en", i), b1.mem_en, vt[i].en);
      if (vt[i].en) chk($sformatf("v%0d_mem_addr", i), b1.mem_addr, vt[i].idx);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", i),  b1.ifu_RVALID,  1'b1);
      chk($sformatf("v%0d_rresp", i),   b1.ifu_RRESP,   vt[i].resp);
      chk($sformatf("v%0d_rdata", i),   b1.ifu_RDATA,   vt[i].data);
      chk($sformatf("v%0d_arready_resp", i), b1.ifu_ARREADY, 1'b1);
      b1.ifu_ARVALID = 1'b0;
      b1.ifu_ARADDR  = ~vt[i].addr;
      #1;
      chk($sformatf("v%0d_mem_en_resp", i), b1.mem_en, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid_done", i), b1.ifu_RVALID, 1'b0);
      chk($sformatf("v%0d_rdata_held", i),  b1.ifu_RDATA,  vt[i].data);
    end

    // LAT=1 back-to-back beats.
    @(negedge clk);
    b1.ifu_ARVALID = 1'b1;
    b1.ifu_ARADDR  = 64'h8000_0004;
    @(negedge clk);
    chk("b2b_rvalid0", b1.ifu_RVALID, 1'b1);
    chk("b2b_rdata0",  b1.ifu_RDATA,  64'h0000_0013_0000_0013);
    b1.ifu_ARADDR = 64'h8000_0008;
    #1;
    chk("b2b_arready", b1.ifu_ARREADY, 1'b1);
    chk("b2b_mem_en",  b1.mem_en,      1'b1);
    chk("b2b_mem_addr", b1.mem_addr,   16'd1);
    @(negedge clk);
    chk("b2b_rvalid1", b1.ifu_RVALID, 1'b1);
    chk("b2b_rdata1",  b1.ifu_RDATA,  64'hA000_0001_B000_0001);
    b1.ifu_ARVALID = 1'b0;
    @(negedge clk);
    chk("b2b_rvalid_done", b1.ifu_RVALID, 1'b0);

    // LAT=3 streaming with ARVALID held: RVALID every 3 cycles.
    @(negedge clk);
    b3.ifu_ARVALID = 1'b1;
    b3.ifu_ARADDR  = a3[0];
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("s3_c%0d_rvalid", c),  b3.ifu_RVALID,  (c % 3 == 0) && (c <= 9));
      chk($sformatf("s3_c%0d_arready", c), b3.ifu_ARREADY, (c % 3 == 0) || (c == 10));
      chk($sformatf("s3_c%0d_mem_en", c),  b3.mem_en,      (c % 3 == 2) && (c <= 8));
      if (c % 3 == 2) chk($sformatf("s3_c%0d_mem_addr", c), b3.mem_addr, 64'(c / 3));
      if ((c % 3 == 0) && (c <= 9)) begin
        chk($sformatf("s3_c%0d_rdata", c), b3.ifu_RDATA, d3[c/3-1]);
        chk($sformatf("s3_c%0d_rresp", c), b3.ifu_RRESP, 2'b00);
      end
      if (c / 3 < 3) b3.ifu_ARADDR = a3[c/3];
      else           b3.ifu_ARVALID = 1'b0;
    end

    // LAT=3 backpressure, then an AR accepted in the same cycle as the R handshake.
    @(negedge clk);
    b3.ifu_RREADY  = 1'b0;
    b3.ifu_ARVALID = 1'b1;
    b3.ifu_ARADDR  = 64'h8000_0008;
    @(negedge clk);
    chk("bp_arready_wait", b3.ifu_ARREADY, 1'b0);
    b3.ifu_ARADDR = 64'h8000_0014;
    @(negedge clk);
    chk("bp_mem_en",   b3.mem_en,   1'b1);
    chk("bp_mem_addr", b3.mem_addr, 16'd1);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp%0d_rvalid", k),  b3.ifu_RVALID,  1'b1);
      chk($sformatf("bp%0d_rdata", k),   b3.ifu_RDATA,   64'hA000_0001_B000_0001);
      chk($sformatf("bp%0d_rresp", k),   b3.ifu_RRESP,   2'b00);
      chk($sformatf("bp%0d_arready", k), b3.ifu_ARREADY, 1'b0);
      if (k < 5) @(negedge clk);
    end
    b3.ifu_RREADY = 1'b1;
    #1;
    chk("bp_arready_release", b3.ifu_ARREADY, 1'b1);
    @(negedge clk);
    chk("bp_next_rvalid_low", b3.ifu_RVALID,  1'b0);
    chk("bp_next_arready",    b3.ifu_ARREADY, 1'b0);
    b3.ifu_ARVALID = 1'b0;
    @(negedge clk);
    chk("bp_next_mem_en",   b3.mem_en,   1'b1);
    chk("bp_next_mem_addr", b3.mem_addr, 16'd2);
    @(negedge clk);
    chk("bp_next_rvalid", b3.ifu_RVALID, 1'b1);
    chk("bp_next_rdata",  b3.ifu_RDATA,  64'hA000_0002_A000_0002);
    @(negedge clk);
    chk("bp_done_rvalid",  b3.ifu_RVALID,  1'b0);
    chk("bp_done_arready", b3.ifu_ARREADY, 1'b1);

    // LAT=3 error responses keep timing and never touch the SRAM.
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      b3.ifu_ARVALID = 1'b1;
      b3.ifu_ARADDR  = ea[e];
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        b3.ifu_ARVALID = 1'b0;
        chk($sformatf("err%0d_c%0d_mem_en", e, c), b3.mem_en, 1'b0);
        chk($sformatf("err%0d_c%0d_rvalid", e, c), b3.ifu_RVALID, c == 3);
        if (c == 3) begin
          chk($sformatf("err%0d_rresp", e), b3.ifu_RRESP, er[e]);
          chk($sformatf("err%0d_rdata", e), b3.ifu_RDATA, 64'h0);
        end
      end
    end

    // LAT=4: asynchronous reset while the read strobe is up aborts the request.
    @(negedge clk);
    b4.ifu_ARVALID = 1'b1;
    b4.ifu_ARADDR  = 64'h8000_0008;
    @(negedge clk);
    b4.ifu_ARVALID = 1'b0;
    chk("ar4_arready_wait", b4.ifu_ARREADY, 1'b0);
    @(negedge clk);
    chk("ar4_mem_en_early", b4.mem_en, 1'b0);
    @(negedge clk);
    chk("ar4_mem_en", b4.mem_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar4_rst_mem_en",  b4.mem_en,      1'b0);
    chk("ar4_rst_arready", b4.ifu_ARREADY, 1'b0);
    chk("ar4_rst_rvalid",  b4.ifu_RVALID,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("ar4_post%0d_rvalid", c),  b4.ifu_RVALID,  1'b0);
      chk($sformatf("ar4_post%0d_arready", c), b4.ifu_ARREADY, 1'b1);
      chk($sformatf("ar4_post%0d_mem_en", c),  b4.mem_en,      1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ifu_rd_responder.md
Name: ifu_rd_responder

Overview:
- Slave end of the instruction-fetch read channel (AR/R with ARPORT and RRESP) driven by the core's fetch controller.
- Accepts one read request at a time and reads a 64-bit-wide synchronous SRAM.
- Returns the fetched word with a configurable, fixed latency and handles RREADY backpressure.
- Range and alignment checks produce error responses without touching the SRAM.

Parameters:
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of SRAM word 0.
- DEPTH_LOG2, 16, log2 of SRAM depth in 64-bit words.
- LAT, 1, cycles from AR handshake edge to RVALID assertion; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ifu_ARVALID  in  1  read address valid.
- ifu_ARREADY  out  1  read address ready.
- ifu_ARADDR  in  64  byte address.
- ifu_ARPORT  in  3  protection bits; captured, no effect on response.
- ifu_RVALID  out  1  read data valid.
- ifu_RREADY  in  1  read data ready.
- ifu_RDATA  out  64  read data.
- ifu_RRESP  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- mem_en  out  1  SRAM read strobe.
- mem_addr  out  DEPTH_LOG2  SRAM word index.
- mem_rdata  in  64  SRAM data, valid the cycle after mem_en; not held.

Behaviour:
- Reset: state IDLE, counter 0. While rst=1: ifu_RVALID=0, ifu_RDATA=0, ifu_RRESP=00, ifu_ARREADY=0, mem_en=0.
- Reset asserted mid-transaction aborts it immediately. No response is delivered after release.
- States:
  - IDLE: ifu_ARREADY=1.
  - WAIT: counting down, ifu_ARREADY=0.
  - RESP: ifu_RVALID=1; ifu_ARREADY=ifu_RREADY.
- AR handshake: ifu_ARVALID & ifu_ARREADY at edge T. Captures ARADDR, ARPORT and the error class.
  - RVALID rises at edge T+LAT.
  - LAT=1: go directly to RESP.
  - LAT>1: enter WAIT, counter=LAT-1, decrement each cycle; go to RESP when the counter reaches 0.
- SRAM read issue:
  - mem_en is asserted in the cycle before RVALID rises, only for OKAY-class requests.
  - mem_addr = (addr-BASE_ADDR)>>3.
  - LAT=1: mem_en and mem_addr are driven combinationally from the handshake cycle (ARVALID&ARREADY, ARADDR).
  - Otherwise they come from captured state.
  - mem_rdata is registered into the RDATA hold register at the RVALID-rising edge.
- Data formatting, OKAY:
  - RDATA[63:32] = word[63:32].
  - RDATA[31:0] = addr[2] ? word[63:32] : word[31:0]. The instruction always sits in [31:0].
- Errors, checked in this priority order:
  - addr[1:0]!=0: RRESP=10, RDATA=0.
  - addr<BASE_ADDR or addr>=BASE_ADDR+(8<<DEPTH_LOG2): RRESP=11, RDATA=0.
  - Error responses keep the same LAT timing and never assert mem_en.
- RESP holds RVALID, RDATA and RRESP stable until ifu_RREADY=1. Backpressure of any length is allowed.
- R handshake at edge E:
  - If ifu_ARVALID=1 in that cycle, the new request is accepted at E. Next RVALID is at E+LAT; LAT=1 gives back-to-back RVALID.
  - Otherwise return to IDLE, with RVALID=0 after E.
- Only one request is outstanding; ARREADY is never high in WAIT.
- ARADDR and ARPORT are ignored when ARVALID=0. RDATA/RRESP values when RVALID=0 are don't-care, but they are held at the last value, never X.
- Address arithmetic is full 64-bit unsigned with no wrap; BASE_ADDR+size overflowing 64 bits is illegal configuration.

Test Plan:
- LAT=1, SRAM[0]=64'h0000_0013_0010_0093: AR 0x8000_0000 at T → mem_en at T, mem_addr=0; RVALID at T+1, RDATA[31:0]=32'h0010_0093, RRESP=00.
- Same setup: AR 0x8000_0004 → RDATA[31:0]=32'h0000_0013.
- LAT=3, RREADY=1, ARVALID held high with addresses 0x8000_0000, 0x8000_0008, 0x8000_0010:
  - RVALID pulses at T+3, T+6, T+9.
  - mem_addr 0, 1, 2 at T+2, T+5, T+8.
  - ARREADY=0 during WAIT.
- Backpressure: RREADY=0 for 5 cycles after RVALID → RDATA/RRESP stable and ARREADY=0. Raising RREADY with ARVALID=1 accepts the next AR in the same cycle.
- Errors: AR 0x8000_0002 → RRESP=10, RDATA=0, mem_en never asserted. AR 0x7FFF_FFFC or 0x8008_0000 (DEPTH_LOG2=16) → RRESP=11.
- Reset: assert rst asynchronously during WAIT (LAT=4) → RVALID, mem_en and ARREADY drop without a clock edge. After release, ARREADY=1 and no stale response appears.
